// File: rtl/bus_copy_engine.sv
// Bus-mastering block copy engine: requests the shared bus, then moves len words
// from src to dst as one read/write pair per word, in ascending address order.
module bus_copy_engine #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [1:0]        m_cmd,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data
);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam int         CNT_W     = $clog2(RD_LAT + 2);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] src_q, src_nx, dst_q, dst_nx, len_q, len_nx, idx_q, idx_nx;
   logic [ADDR_W-1:0] idx_inc;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;
   logic [DATA_W-1:0] data_q, data_nx;
   logic              busy_nx, done_nx, req_nx;
   logic [1:0]        cmd_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx;

   assign idx_inc = idx_q + ADDR_W'(1);

   always_comb begin
      state_nx = state;
      src_nx   = src_q;
      dst_nx   = dst_q;
      len_nx   = len_q;
      idx_nx   = idx_q;
      cnt_nx   = '0;
      data_nx  = data_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               src_nx   = src_addr;
               dst_nx   = dst_addr;
               len_nx   = len;
               idx_nx   = '0;
               state_nx = (len == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (bus_gnt) state_nx = S_RD;
         end
         S_RD: begin
            // address held for RD_LAT+1 cycles; data is sampled on the final edge
            if (cnt_q == CNT_W'(RD_LAT)) begin
               data_nx  = read_data;
               state_nx = S_WR;
            end else begin
               cnt_nx = cnt_q + CNT_W'(1);
            end
         end
         S_WR: begin
            idx_nx = idx_inc;
            if (idx_inc == len_q)  state_nx = S_DONE;
            else if (bus_gnt)      state_nx = S_RD;
            else                   state_nx = S_REQ;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      // outputs are registered, so they are decoded from the state being entered
      busy_nx  = (state_nx != S_IDLE);
      done_nx  = (state_nx == S_DONE);
      req_nx   = (state_nx == S_REQ) || (state_nx == S_RD) || (state_nx == S_WR);
      cmd_nx   = CMD_NONE;
      addr_nx  = '0;
      wdata_nx = '0;
      if (state_nx == S_RD) begin
         cmd_nx  = CMD_READ;
         addr_nx = src_nx + idx_nx;
      end else if (state_nx == S_WR) begin
         cmd_nx   = CMD_WRITE;
         addr_nx  = dst_nx + idx_nx;
         wdata_nx = data_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bus_req    <= 1'b0;
         m_cmd      <= CMD_NONE;
         m_addr     <= '0;
         write_data <= '0;
      end else begin
         state      <= state_nx;
         src_q      <= src_nx;
         dst_q      <= dst_nx;
         len_q      <= len_nx;
         idx_q      <= idx_nx;
         cnt_q      <= cnt_nx;
         data_q     <= data_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         bus_req    <= req_nx;
         m_cmd      <= cmd_nx;
         m_addr     <= addr_nx;
         write_data <= wdata_nx;
      end
   end

endmodule

// File: tb/tb_bus_copy_engine.sv
// Scoreboard bench for bus_copy_engine: a word-level copy model predicts every
// bus read/write and done pulse; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_bus_copy_engine;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              bus_gnt = 1'b0;
   logic [ADDR_W-1:0] src_addr = '0, dst_addr = '0, len = '0;
   logic              busy, done, bus_req;
   logic [1:0]        m_cmd;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data = '0;

   bus_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .bus_req(bus_req),
      .bus_gnt(bus_gnt), .m_cmd(m_cmd), .m_addr(m_addr), .write_data(write_data),
      .read_data(read_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event occurred with nothing expected", name);
   endtask

   // ---------------- responders: RAM (addr[8]=0), LED at 0x100, SW at 0x140
   function automatic logic [DATA_W-1:0] init_val(input logic [7:0] a);
      case (a)
         8'h10:   return 16'hA1A1;
         8'h11:   return 16'hB2B2;
         8'h12:   return 16'hC3C3;
         8'h13:   return 16'hD4D4;
         8'h30:   return 16'h00A5;
         default: return {a, ~a};
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] io_read(input logic [ADDR_W-1:0] a, input logic [7:0] s);
      if (a == 9'h140) return {{8{s[7]}}, s};
      return 16'hE000 | {7'd0, a};
   endfunction

   logic [DATA_W-1:0] ram [256];
   logic [7:0]        led = '0;
   logic [7:0]        sw = '0;
   bit                loaded = 1'b0;

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
         loaded <= 1'b1;
      end
      if (m_cmd == 2'b01) read_data <= m_addr[8] ? io_read(m_addr, sw) : ram[m_addr[7:0]];
      else                read_data <= 16'hDEAD;
      if (m_cmd == 2'b10) begin
         if (!m_addr[8])            ram[m_addr[7:0]] <= write_data;
         else if (m_addr == 9'h100) led <= write_data[7:0];
      end
   end

   // ---------------- reference model and scoreboard queues
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] old;
   } wr_t;

   logic [DATA_W-1:0] ref_ram [256];
   logic [7:0]        ref_led = '0;
   wr_t               wr_q[$];
   logic [ADDR_W-1:0] rd_q[$];
   int                done_q[$];
   int                writes_seen = 0;

   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      if (!a[8])        return ref_ram[a[7:0]];
      if (a == 9'h100)  return {8'h00, ref_led};
      return io_read(a, sw);
   endfunction

   function automatic void ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (!a[8])            ref_ram[a[7:0]] = d;
      else if (a == 9'h100) ref_led = d[7:0];
   endfunction

   function automatic logic [DATA_W-1:0] ref_peek(input logic [ADDR_W-1:0] a);
      if (!a[8])       return ref_ram[a[7:0]];
      if (a == 9'h100) return {8'h00, ref_led};
      return '0;
   endfunction

   task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [ADDR_W-1:0] n, input bit timed);
      wr_t w;
      int  c;
      for (int i = 0; i < int'(n); i++) begin
         rd_q.push_back(s + ADDR_W'(i));
         w.addr = d + ADDR_W'(i);
         w.data = ref_read(s + ADDR_W'(i));
         w.old  = ref_peek(w.addr);
         ref_write(w.addr, w.data);
         wr_q.push_back(w);
      end
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; len = n; start = 1'b1;
      c = cyc;
      if (!timed)         done_q.push_back(-1);
      else if (n == '0)   done_q.push_back(c + 1);
      else                done_q.push_back(c + 2 + (RD_LAT + 2) * int'(n));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input bit rand_gnt);
      int n = 0;
      while ((busy || done_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
      end
      check("idle_within_budget", 32'(n < budget), 32'd1);
      wr_q.delete(); rd_q.delete(); done_q.delete();
      bus_gnt = 1'b1;
   endtask

   task automatic check_mem(input string name);
      int diffs = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) diffs++;
      check(name, 32'(diffs), 32'd0);
      check({name, "_led"}, 32'(led), 32'(ref_led));
   endtask

   // ---------------- monitor
   logic [1:0]        prev_cmd = 2'b00;
   logic [ADDR_W-1:0] prev_addr = '0;

   always @(negedge clk) begin
      wr_t w;
      int  e;
      logic [ADDR_W-1:0] ra;
      if (reset_n) begin
         if (m_cmd == 2'b01 && prev_cmd != 2'b01) begin
            if (rd_q.size() == 0) fail_now("rd_unexpected");
            else begin
               ra = rd_q.pop_front();
               check("rd_addr", 32'(m_addr), 32'(ra));
            end
         end
         if (m_cmd == 2'b01 && prev_cmd == 2'b01) check("rd_addr_stable", 32'(m_addr), 32'(prev_addr));
         if (m_cmd == 2'b10) begin
            if (wr_q.size() == 0) fail_now("wr_unexpected");
            else begin
               w = wr_q.pop_front();
               check("wr_addr", 32'(m_addr), 32'(w.addr));
               check("wr_data", 32'(write_data), 32'(w.data));
               writes_seen++;
            end
         end
         if (done) begin
            if (done_q.size() == 0) fail_now("done_unexpected");
            else begin
               e = done_q.pop_front();
               if (e >= 0) check("done_cycle", 32'(cyc), 32'(e));
            end
         end
      end
      prev_cmd  = m_cmd;
      prev_addr = m_addr;
   end

   // ---------------- stimulus
   initial begin
      logic [DATA_W-1:0] t1v [4];
      int base, n;
      wr_t w;
      t1v = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4};
      for (int i = 0; i < 256; i++) ref_ram[i] = init_val(8'(i));

      repeat (3) @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_m_cmd", 32'(m_cmd), 32'd0);
      check("rst_m_addr", 32'(m_addr), 32'd0);
      check("rst_write_data", 32'(write_data), 32'd0);
      reset_n = 1'b1;
      bus_gnt = 1'b1;

      // T1 basic copy with grant held
      issue(9'h010, 9'h040, 9'd4, 1'b1);
      wait_idle(60, 1'b0);
      for (int i = 0; i < 4; i++) check("t1_dst_word", 32'(ram[8'h40 + 8'(i)]), 32'(t1v[i]));
      check_mem("t1_mem");

      // T2 zero length
      issue(9'h020, 9'h050, 9'd0, 1'b1);
      check("t2_done", 32'(done), 32'd1);
      check("t2_bus_req", 32'(bus_req), 32'd0);
      check("t2_m_cmd", 32'(m_cmd), 32'd0);
      wait_idle(10, 1'b0);

      // T3 source address wrap
      issue(9'h1FE, 9'h050, 9'd3, 1'b1);
      wait_idle(60, 1'b0);
      check_mem("t3_mem");

      // T4 grant withheld, then dropped after the first word
      bus_gnt = 1'b0;
      issue(9'h060, 9'h070, 9'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("t4_wait_cmd", 32'(m_cmd), 32'd0);
         check("t4_wait_req", 32'(bus_req), 32'd1);
         check("t4_wait_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
      end
      bus_gnt = 1'b1;
      n = 0;
      while (m_cmd != 2'b10 && n < 50) begin @(negedge clk); n++; end
      check("t4_first_wr_seen", 32'(n < 50), 32'd1);
      #1 bus_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("t4_pause_cmd", 32'(m_cmd), 32'd0);
         check("t4_pause_busy", 32'(busy), 32'd1);
      end
      bus_gnt = 1'b1;
      wait_idle(60, 1'b0);
      check_mem("t4_mem");

      // T5 I/O space: LED write and sign-extended switch read
      issue(9'h030, 9'h100, 9'd1, 1'b1);
      wait_idle(20, 1'b0);
      check("t5_led", 32'(led), 32'h0000_00A5);
      sw = 8'h81;
      issue(9'h140, 9'h020, 9'd1, 1'b1);
      wait_idle(20, 1'b0);
      check("t5_sw_word", 32'(ram[8'h20]), 32'h0000_FF81);
      check_mem("t5_mem");

      // T6 reset in the middle of the third read
      base = writes_seen;
      issue(9'h080, 9'h090, 9'd5, 1'b1);
      n = 0;
      while (!((writes_seen - base) >= 2 && m_cmd == 2'b01) && n < 100) begin
         @(negedge clk); n++;
      end
      check("t6_reached_rd", 32'(n < 100), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_cmd", 32'(m_cmd), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_req", 32'(bus_req), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      while (wr_q.size() > 0) begin
         w = wr_q.pop_back();
         if (!w.addr[8])            ref_ram[w.addr[7:0]] = w.old;
         else if (w.addr == 9'h100) ref_led = w.old[7:0];
      end
      rd_q.delete(); done_q.delete();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      check("t6_idle_after_rst", 32'(busy), 32'd0);
      check_mem("t6_partial_mem");
      issue(9'h080, 9'h090, 9'd5, 1'b1);
      wait_idle(60, 1'b0);
      check_mem("t6_mem");

      // randomized copies, alternating held and random grant
      for (int it = 0; it < 8; it++) begin
         bit timed;
         timed = (it % 2 == 0);
         issue(9'($urandom_range(0, 255)), 9'($urandom_range(0, 255)),
               9'($urandom_range(1, 10)), timed);
         wait_idle(300, !timed);
         check_mem("rand_mem");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
